// File: rtl/reset_seq_pkg.sv
// Shared types and constants for the staged reset sequencer.
package reset_seq_pkg;

    typedef enum logic [1:0] {
        WAIT_LOCK = 2'd0,
        FILTER    = 2'd1,
        RELEASE   = 2'd2,
        RUN       = 2'd3
    } rseq_state_t;

    localparam logic [7:0] LOCK_LOSS_MAX = 8'hFF;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous bit, with selectable reset value.
module sync_2ff #(
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta <= RST_VAL;
            q    <= RST_VAL;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/reset_sequencer.sv
// Staged reset generator: filters PLL lock, debounces the board button and
// releases per-domain resets in order, re-asserting them all together on any event.
module reset_sequencer
    import reset_seq_pkg::*;
#(
    parameter int LOCK_FILTER_CYCLES  = 1024,
    parameter int HOLD_CYCLES         = 16,
    parameter int BTN_DEBOUNCE_CYCLES = 100000,
    parameter int NUM_STAGES          = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  pll_locked,
    input  logic                  btn_rst_n,
    input  logic                  sw_rst,
    output logic [NUM_STAGES-1:0] stage_rst,
    output logic                  ready,
    output logic [7:0]            lock_loss_count
);

    localparam int FW = (LOCK_FILTER_CYCLES  > 1) ? $clog2(LOCK_FILTER_CYCLES)  : 1;
    localparam int HW = (HOLD_CYCLES         > 1) ? $clog2(HOLD_CYCLES)         : 1;
    localparam int DW = (BTN_DEBOUNCE_CYCLES > 1) ? $clog2(BTN_DEBOUNCE_CYCLES) : 1;
    localparam int IW = (NUM_STAGES          > 1) ? $clog2(NUM_STAGES)          : 1;

    logic          lock_s;
    logic          btn_s;
    logic          btn_press;
    logic [DW-1:0] db_cnt;
    logic [FW-1:0] filt_cnt;
    logic [HW-1:0] hold_cnt;
    logic [IW-1:0] idx;
    rseq_state_t   state;

    sync_2ff #(.RST_VAL(1'b0)) u_lock_sync (.clk(clk), .rst(rst), .d(pll_locked), .q(lock_s));
    sync_2ff #(.RST_VAL(1'b1)) u_btn_sync  (.clk(clk), .rst(rst), .d(btn_rst_n),  .q(btn_s));

    // Press registers after the full low window and holds while the button stays low.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            db_cnt    <= '0;
            btn_press <= 1'b0;
        end else if (btn_s) begin
            db_cnt    <= '0;
            btn_press <= 1'b0;
        end else if (db_cnt == DW'(BTN_DEBOUNCE_CYCLES - 1)) begin
            btn_press <= 1'b1;
        end else begin
            db_cnt <= db_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state           <= WAIT_LOCK;
            stage_rst       <= '1;
            ready           <= 1'b0;
            lock_loss_count <= '0;
            filt_cnt        <= '0;
            hold_cnt        <= '0;
            idx             <= '0;
        end else begin
            case (state)
                WAIT_LOCK: begin
                    stage_rst <= '1;
                    ready     <= 1'b0;
                    if (lock_s) begin
                        state    <= FILTER;
                        filt_cnt <= '0;
                    end
                end
                FILTER: begin
                    if (!lock_s) begin
                        state <= WAIT_LOCK;
                    end else if (filt_cnt == FW'(LOCK_FILTER_CYCLES - 1)) begin
                        state    <= RELEASE;
                        idx      <= '0;
                        hold_cnt <= '0;
                    end else begin
                        filt_cnt <= filt_cnt + 1'b1;
                    end
                end
                RELEASE, RUN: begin
                    if (!lock_s) begin
                        stage_rst <= '1;
                        ready     <= 1'b0;
                        state     <= WAIT_LOCK;
                        if (lock_loss_count != LOCK_LOSS_MAX)
                            lock_loss_count <= lock_loss_count + 1'b1;
                    end else if (btn_press || sw_rst) begin
                        // Lock is still good, so restart the stage sequence without re-filtering.
                        stage_rst <= '1;
                        ready     <= 1'b0;
                        state     <= RELEASE;
                        idx       <= '0;
                        hold_cnt  <= '0;
                    end else if (state == RUN) begin
                        ready <= 1'b1;
                    end else if (hold_cnt == HW'(HOLD_CYCLES - 1)) begin
                        stage_rst[idx] <= 1'b0;
                        hold_cnt       <= '0;
                        if (idx == IW'(NUM_STAGES - 1))
                            state <= RUN;
                        else
                            idx <= idx + 1'b1;
                    end else begin
                        hold_cnt <= hold_cnt + 1'b1;
                    end
                end
                default: state <= WAIT_LOCK;
            endcase
        end
    end

endmodule

// File: tb/tb_reset_sequencer.sv
// Randomized scoreboard bench for reset_sequencer against an elapsed-time reference model.
module tb_reset_sequencer;

    localparam int L = 4;
    localparam int H = 2;
    localparam int B = 8;
    localparam int N = 3;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         pll_locked = 1'b0;
    logic         btn_rst_n = 1'b1;
    logic         sw_rst = 1'b0;
    logic [N-1:0] stage_rst;
    logic         ready;
    logic [7:0]   lock_loss_count;

    always #50 clk = ~clk;

    reset_sequencer #(
        .LOCK_FILTER_CYCLES (L),
        .HOLD_CYCLES        (H),
        .BTN_DEBOUNCE_CYCLES(B),
        .NUM_STAGES         (N)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .pll_locked     (pll_locked),
        .btn_rst_n      (btn_rst_n),
        .sw_rst         (sw_rst),
        .stage_rst      (stage_rst),
        .ready          (ready),
        .lock_loss_count(lock_loss_count)
    );

    typedef struct packed {
        logic [N-1:0] st;
        logic         rdy;
        logic [7:0]   llc;
    } exp_t;

    exp_t sb[$];
    int   vectors = 0;
    int   miscompares = 0;

    // Reference model: lock history, consecutive-run counts and time since the
    // current release sequence began; outputs derive from elapsed time.
    bit   h0, h1, b0, b1, in_reset, lk, bs, press;
    int   lock_run, elapsed, low_run, loss;
    exp_t me;

    always @(posedge clk) begin
        if (rst) begin
            h0 = 0; h1 = 0; b0 = 1; b1 = 1;
            in_reset = 1; lock_run = 0; elapsed = 0; low_run = 0; loss = 0;
        end else begin
            lk = h1; bs = b1; press = (low_run >= B);
            h1 = h0; h0 = pll_locked;
            b1 = b0; b0 = btn_rst_n;
            low_run = bs ? 0 : ((low_run < B) ? low_run + 1 : B);
            if (in_reset) begin
                if (lk) begin
                    lock_run++;
                    if (lock_run == L + 1) begin
                        in_reset = 0;
                        elapsed = 0;
                    end
                end else begin
                    lock_run = 0;
                end
            end else if (!lk) begin
                in_reset = 1;
                lock_run = 0;
                if (loss < 255) loss++;
            end else if (press || sw_rst) begin
                elapsed = 0;
            end else if (elapsed < N * H + 1) begin
                elapsed++;
            end
        end
        for (int k = 0; k < N; k++) me.st[k] = in_reset || (elapsed < (k + 1) * H);
        me.rdy = !in_reset && (elapsed >= N * H + 1);
        me.llc = loss[7:0];
        sb.push_back(me);
    end

    exp_t got, want;
    always @(posedge clk) begin
        #1;
        if (sb.size() > 0) begin
            want = sb.pop_front();
            got  = {stage_rst, ready, lock_loss_count};
            vectors++;
            if (got !== want) begin
                miscompares++;
                $display("FAIL cycle_check t=%0t stage_rst=%b want %b ready=%b want %b lock_loss_count=%0d want %0d",
                         $time, got.st, want.st, got.rdy, want.rdy, got.llc, want.llc);
            end
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        cyc(3);
        rst = 1'b0;
        cyc(2);
        pll_locked = 1'b1;
        cyc(25);

        repeat (4) begin
            sw_rst = 1'b1; cyc(1); sw_rst = 1'b0;
            cyc($urandom_range(3, 12));
        end

        repeat (6) begin
            btn_rst_n = 1'b0; cyc($urandom_range(1, 7));
            btn_rst_n = 1'b1; cyc($urandom_range(1, 5));
        end
        btn_rst_n = 1'b0; cyc(20);
        btn_rst_n = 1'b1; cyc(15);

        // Lock glitch while the filter is running.
        pll_locked = 1'b0; cyc(2);
        pll_locked = 1'b1; cyc(3);
        pll_locked = 1'b0; cyc(1);
        pll_locked = 1'b1; cyc(20);

        // Async reset partway through the stage release.
        pll_locked = 1'b0; cyc(2);
        pll_locked = 1'b1; cyc(2 + L + 5);
        #10 rst = 1'b1;
        #1;
        vectors++;
        if (stage_rst !== {N{1'b1}} || ready !== 1'b0) begin
            miscompares++;
            $display("FAIL async_rst stage_rst=%b want %b ready=%b want 0", stage_rst, {N{1'b1}}, ready);
        end
        cyc(2);
        rst = 1'b0;
        cyc(20);

        repeat (258) begin
            pll_locked = 1'b0; cyc(2);
            pll_locked = 1'b1; cyc(9);
        end
        cyc(2);
        vectors++;
        if (lock_loss_count !== 8'd255) begin
            miscompares++;
            $display("FAIL lock_loss_saturate lock_loss_count=%0d want 255", lock_loss_count);
        end

        repeat (1500) begin
            sw_rst     = ($urandom_range(0, 39) == 0);
            pll_locked = ($urandom_range(0, 199) != 0);
            if (btn_rst_n && $urandom_range(0, 59) == 0) btn_rst_n = 1'b0;
            else if (!btn_rst_n && $urandom_range(0, 5) == 0) btn_rst_n = 1'b1;
            cyc(1);
        end
        sw_rst = 1'b0; pll_locked = 1'b1; btn_rst_n = 1'b1;
        cyc(20);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/reset_sequencer.md
Name: reset_sequencer

Overview:
- Sits directly downstream of the 25->10 MHz ECP5 PLL wrapper and runs entirely in the 10 MHz PLL output domain.
- Consumes the PLL lock flag, a board reset button and a CPU soft-reset request.
- Produces staged, ordered, glitch-free active-high resets for SoC sub-domains (e.g. bus/memory, CPU, peripherals), plus a ready flag and a lock-loss counter.

Parameters:
- LOCK_FILTER_CYCLES, 1024: consecutive synchronized-lock-high cycles required before any reset is released.
- HOLD_CYCLES, 16: cycles between successive stage releases (also applies before stage 0).
- BTN_DEBOUNCE_CYCLES, 100000: consecutive low cycles on the button required to register a press (10 ms at 10 MHz).
- NUM_STAGES, 3: number of reset outputs; minimum 1.

Ports:
- clk  in  1  10 MHz PLL output clock.
- rst  in  1  asynchronous, active-high master reset.
- pll_locked  in  1  PLL lock flag; asynchronous to clk.
- btn_rst_n  in  1  board button, active-low, asynchronous, bouncing.
- sw_rst  in  1  synchronous single-cycle soft-reset request from the CPU.
- stage_rst  out  NUM_STAGES  per-domain resets, active-high; bit 0 is released first.
- ready  out  1  high only when all stages are released.
- lock_loss_count  out  8  saturating count of lock losses after filtering.

Behaviour:
- Clock and reset: one clock, clk. Reset rst is asynchronous and active-high.
- On rst: stage_rst = all ones asynchronously, ready = 0, lock_loss_count = 0, state = WAIT_LOCK, all counters = 0. Synchronizer flops reset to lock = 0, btn = 1.
- Release of every output is synchronous. All outputs come straight from flops, with no combinational paths from inputs.
- pll_locked and btn_rst_n pass through 2-FF synchronizers, giving lock_s and btn_s with 2-cycle latency.
- Debounce: btn_press = 1 once btn_s has been low for BTN_DEBOUNCE_CYCLES consecutive cycles. It stays 1 while btn_s is low. The counter clears whenever btn_s = 1.
- WAIT_LOCK: stage_rst all ones. When lock_s = 1, go to FILTER with filt_cnt = 0.
- FILTER: each cycle with lock_s = 1:
  - if filt_cnt == LOCK_FILTER_CYCLES-1, go to RELEASE with idx = 0, hold_cnt = 0;
  - else filt_cnt++.
  - If lock_s = 0, go to WAIT_LOCK. No count increment.
- RELEASE: hold_cnt++ each cycle. When hold_cnt == HOLD_CYCLES-1:
  - clear stage_rst[idx] on that edge and reset hold_cnt to 0;
  - if idx == NUM_STAGES-1, go to RUN; else idx++.
- RUN: ready = 1, registered, so it rises one cycle after the last stage is released.
- Events in RELEASE or RUN, highest priority first:
  - lock_s = 0: on the next edge, stage_rst = all ones, ready = 0, state = WAIT_LOCK, lock_loss_count++ (saturates at 255).
  - btn_press = 1: stage_rst = all ones, ready = 0, state = RELEASE, idx = 0, hold_cnt held at 0 while btn_press stays 1. PLL lock is not re-filtered.
  - sw_rst = 1: same as btn_press for one cycle; the sequence then restarts from stage 0.
- sw_rst and btn_press are ignored in WAIT_LOCK and FILTER; reset is already asserted there.
- Timing: lock rising (first sampled at edge t0) with no interruptions gives
  - stage_rst[k] falling at edge t0 + 2 + LOCK_FILTER_CYCLES + (k+1)*HOLD_CYCLES;
  - ready rising at t0 + 3 + LOCK_FILTER_CYCLES + NUM_STAGES*HOLD_CYCLES.
- Stage outputs never deassert out of order. Once reasserted, all bits reassert together on the same edge.
- Counter widths are $clog2 of the respective parameter, minimum 1.

Decomposition:
- Shared package reset_seq_pkg holds:
  - state enum rseq_state_t {WAIT_LOCK, FILTER, RELEASE, RUN};
  - constant LOCK_LOSS_MAX = 8'hFF.
- Sub-module sync_2ff (parameterised reset value) is instantiated twice, for lock and button. It is reusable elsewhere in the SoC.
- Debounce logic stays inline.

Test Plan:
- LOCK_FILTER_CYCLES=4, HOLD_CYCLES=2, NUM_STAGES=3; rst released, pll_locked rises at edge t0 -> stage_rst 111->110 at t0+8, 100 at t0+10, 000 at t0+12; ready=1 at t0+13; lock_loss_count=0.
- Lock glitch: pll_locked high 3 cycles then low 1 cycle, during FILTER -> stage_rst stays 111, count stays 0; the filter restarts from 0 after lock returns.
- Lock drop in RUN -> stage_rst=111 and ready=0 two sync cycles + 1 edge after the drop; lock_loss_count 0->1. 256 repeated drops -> count saturates at 255.
- sw_rst pulse in RUN -> stage_rst=111 next edge; release resumes 2/4/6 cycles later in order; ready returns 7 cycles after the pulse edge.
- BTN_DEBOUNCE_CYCLES=8; button bounces with low pulses <8 cycles -> no effect. Button held low 20 cycles -> reset asserted after 2+8 cycles, held until release, then sequence from stage 0.
- Async rst asserted mid-RELEASE, between edges -> stage_rst=111 and ready=0 immediately, without waiting for a clock edge; after deassert the full lock filter is repeated.
